// File: rtl/ks_adder_pipe_pkg.sv
`default_nettype none
// ============================================================================
// Module   : adder_pkg
// Brief    : Shared types and helpers for the pipelined Kogge-Stone adder.
// Revision : 1.0 - initial release
// ============================================================================
package adder_pkg;

    localparam int WIDTH_DEF = 64;
    localparam int TAG_W_DEF = 8;

    // Fields are sized for the default widths; narrower instances leave the
    // upper bits at zero so the prefix network carries nothing into them.
    typedef struct packed {
        logic                 valid;
        logic [WIDTH_DEF-1:0] p;
        logic [WIDTH_DEF-1:0] g;
        logic [WIDTH_DEF-1:0] p_orig;
        logic                 c_in;
        logic [TAG_W_DEF-1:0] tag;
    } pg_stage_t;

    function automatic int ks_levels(input int width);
        int lvl;
        lvl = 0;
        while ((1 << lvl) < width) lvl = lvl + 1;
        return lvl;
    endfunction

endpackage
`default_nettype wire

// File: rtl/ks_adder_pipe_prefix_stage.sv
`default_nettype none
// ============================================================================
// Module   : ks_prefix_stage
// Brief    : One Kogge-Stone prefix level (distance DIST) with its register.
// Revision : 1.0 - initial release
// ============================================================================
module ks_prefix_stage
    import adder_pkg::*;
#(
    parameter int WIDTH = WIDTH_DEF,
    parameter int TAG_W = TAG_W_DEF,
    parameter int DIST  = 1
) (
    input  logic      clk,
    input  logic      rst,
    input  pg_stage_t i_stage,
    input  logic      i_dn_ready,
    output pg_stage_t o_stage
);

    localparam logic [WIDTH_DEF-1:0] c_LOW_MASK = (WIDTH_DEF'(1) << DIST) - WIDTH_DEF'(1);
    localparam logic [WIDTH_DEF-1:0] c_LIVE     = WIDTH_DEF'({WIDTH{1'b1}});
    localparam logic [TAG_W_DEF-1:0] c_TAG_LIVE = TAG_W_DEF'({TAG_W{1'b1}});

    pg_stage_t r_stage;
    pg_stage_t w_next;
    logic      w_load;

    // Bits below DIST have no partner at this level and pass through.
    always_comb begin
        w_next     = i_stage;
        w_next.g   = (i_stage.g | (i_stage.p & (i_stage.g << DIST))) & c_LIVE;
        w_next.p   = (i_stage.p & ((i_stage.p << DIST) | c_LOW_MASK)) & c_LIVE;
        w_next.tag = i_stage.tag & c_TAG_LIVE;
    end

    assign w_load = !r_stage.valid || i_dn_ready;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_stage <= '0;
        end else if (w_load) begin
            if (i_stage.valid) begin
                r_stage <= w_next;
            end else begin
                r_stage.valid <= 1'b0;
            end
        end
    end

    assign o_stage = r_stage;

endmodule
`default_nettype wire

// File: rtl/ks_adder_pipe.sv
`default_nettype none
// ============================================================================
// Module   : ks_adder_pipe
// Brief    : Flow-controlled Kogge-Stone adder, one prefix level per stage.
// Revision : 1.0 - initial release
// ============================================================================
module ks_adder_pipe
    import adder_pkg::*;
#(
    parameter int WIDTH = WIDTH_DEF,
    parameter int TAG_W = TAG_W_DEF
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] in_a,
    input  logic [WIDTH-1:0] in_b,
    input  logic             in_c,
    input  logic [TAG_W-1:0] in_tag,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] out_sum,
    output logic             out_cout,
    output logic [TAG_W-1:0] out_tag,
    output logic             busy
);

    localparam int c_LEVELS = ks_levels(WIDTH);

    pg_stage_t        r_s0;
    pg_stage_t        w_s0;
    pg_stage_t        w_stg [0:c_LEVELS];
    logic             w_rdy [0:c_LEVELS+1];
    logic             r_out_valid;
    logic [WIDTH-1:0] r_out_sum;
    logic             r_out_cout;
    logic [TAG_W-1:0] r_out_tag;
    logic             w_unused_p;

    // Carry-in is folded into g[0] so the prefix tree yields true carries.
    always_comb begin
        w_s0                   = '0;
        w_s0.valid             = in_valid;
        w_s0.p[WIDTH-1:0]      = in_a ^ in_b;
        w_s0.g[WIDTH-1:0]      = in_a & in_b;
        w_s0.g[0]              = (in_a[0] & in_b[0]) | ((in_a[0] ^ in_b[0]) & in_c);
        w_s0.p_orig[WIDTH-1:0] = in_a ^ in_b;
        w_s0.c_in              = in_c;
        w_s0.tag[TAG_W-1:0]    = in_tag;
    end

    // Ready ripples back from SOUT: a stage may load when it is empty or
    // its own content is leaving, which collapses bubbles.
    always_comb begin
        w_rdy[c_LEVELS+1] = !r_out_valid || out_ready;
        for (int k = c_LEVELS; k >= 0; k--) begin
            w_rdy[k] = !w_stg[k].valid || w_rdy[k+1];
        end
    end

    assign in_ready = w_rdy[0] && !reset;

    always_ff @(posedge clk) begin
        if (reset) begin
            r_s0 <= '0;
        end else if (w_rdy[0]) begin
            if (in_valid) begin
                r_s0 <= w_s0;
            end else begin
                r_s0.valid <= 1'b0;
            end
        end
    end

    assign w_stg[0] = r_s0;

    for (genvar k = 1; k <= c_LEVELS; k++) begin : g_level
        ks_prefix_stage #(
            .WIDTH (WIDTH),
            .TAG_W (TAG_W),
            .DIST  (1 << (k - 1))
        ) u_stage (
            .clk        (clk),
            .rst        (reset),
            .i_stage    (w_stg[k-1]),
            .i_dn_ready (w_rdy[k+1]),
            .o_stage    (w_stg[k])
        );
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_out_valid <= 1'b0;
            r_out_sum   <= '0;
            r_out_cout  <= 1'b0;
            r_out_tag   <= '0;
        end else if (w_rdy[c_LEVELS+1]) begin
            r_out_valid <= w_stg[c_LEVELS].valid;
            if (w_stg[c_LEVELS].valid) begin
                r_out_sum  <= w_stg[c_LEVELS].p_orig[WIDTH-1:0]
                            ^ {w_stg[c_LEVELS].g[WIDTH-2:0], w_stg[c_LEVELS].c_in};
                r_out_cout <= w_stg[c_LEVELS].g[WIDTH-1];
                r_out_tag  <= w_stg[c_LEVELS].tag[TAG_W-1:0];
            end
        end
    end

    // Group propagate is not needed once the last level has resolved carries.
    assign w_unused_p = ^w_stg[c_LEVELS].p;

    always_comb begin
        busy = r_out_valid;
        for (int k = 0; k <= c_LEVELS; k++) begin
            busy = busy | w_stg[k].valid;
        end
    end

    assign out_valid = r_out_valid;
    assign out_sum   = r_out_sum;
    assign out_cout  = r_out_cout;
    assign out_tag   = r_out_tag;

endmodule
`default_nettype wire
